// File: rtl/enc_pkg.sv
// Shared definitions for the RV32I instruction encoder.
//   enc_op_e    : micro-op codes accepted on req_op (values above 37 are illegal)
//   enc_fmt_e   : instruction format selected by the op decoder
//   enc_state_e : run FSM states
//   OPC_*       : major opcodes, NOP_INSTR is "addi x0,x0,0"
//   fits_signed : true when a 32-bit value is representable as a w-bit signed field
package enc_pkg;

    typedef enum logic [5:0] {
        OP_ADD   = 6'd0,  OP_SUB,  OP_SLL,  OP_SLT,  OP_SLTU, OP_XOR,
        OP_SRL,  OP_SRA,  OP_OR,   OP_AND,
        OP_ADDI  = 6'd10, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB    = 6'd19, OP_LH,   OP_LW,   OP_LBU,  OP_LHU,
        OP_SB    = 6'd24, OP_SH,   OP_SW,
        OP_BEQ   = 6'd27, OP_BNE,  OP_BLT,  OP_BGE,  OP_BLTU, OP_BGEU,
        OP_LUI   = 6'd33, OP_AUIPC, OP_JAL, OP_JALR,
        OP_NOP   = 6'd37
    } enc_op_e;

    typedef enum logic [2:0] {
        FMT_NOP = 3'd0, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } enc_fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Value fits a w-bit signed field when everything above bit w-2 is a sign copy.
    function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] w);
        logic [31:0] hi;
        hi = $signed(v) >>> (w - 5'd1);
        return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_format_enc.sv
// Purely combinational RV32I encoder: micro-op plus fields -> 32-bit word.
// Ports:
//   op[5:0]          micro-op (enc_op_e); values > 37 flag illegal
//   rd/rs1/rs2[4:0]  register indices (ignored where the format has no such field)
//   imm[31:0]        immediate (byte offset for B/J, upper-20 value in [19:0] for U)
//   instr[31:0]      encoded word, NOP on illegal op or range fault
//   illegal          op outside the defined table
//   range_fault      immediate not representable (only with IMM_RANGE_CHECK_EN)
// Build option: IMM_RANGE_CHECK_EN enables immediate range checking; otherwise
// immediates are silently truncated to the field width.
module instr_format_enc
    import enc_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        illegal,
    output logic        range_fault
);

    enc_fmt_e    fmt_s;
    logic [6:0]  opc_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [31:0] raw_s;

    // Op decode: format, major opcode, funct3, funct7.
    always_comb begin
        fmt_s   = FMT_NOP;
        opc_s   = OPC_OPIMM;
        f3_s    = 3'd0;
        f7_s    = 7'd0;
        illegal = 1'b0;
        case (enc_op_e'(op))
            OP_ADD:   begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd0; end
            OP_SUB:   begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd0; f7_s = 7'h20; end
            OP_SLL:   begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd1; end
            OP_SLT:   begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd2; end
            OP_SLTU:  begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd3; end
            OP_XOR:   begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd4; end
            OP_SRL:   begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd5; end
            OP_SRA:   begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd5; f7_s = 7'h20; end
            OP_OR:    begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd6; end
            OP_AND:   begin fmt_s = FMT_R;  opc_s = OPC_OP; f3_s = 3'd7; end
            OP_ADDI:  begin fmt_s = FMT_I;  f3_s = 3'd0; end
            OP_SLTI:  begin fmt_s = FMT_I;  f3_s = 3'd2; end
            OP_SLTIU: begin fmt_s = FMT_I;  f3_s = 3'd3; end
            OP_XORI:  begin fmt_s = FMT_I;  f3_s = 3'd4; end
            OP_ORI:   begin fmt_s = FMT_I;  f3_s = 3'd6; end
            OP_ANDI:  begin fmt_s = FMT_I;  f3_s = 3'd7; end
            OP_SLLI:  begin fmt_s = FMT_SH; f3_s = 3'd1; end
            OP_SRLI:  begin fmt_s = FMT_SH; f3_s = 3'd5; end
            OP_SRAI:  begin fmt_s = FMT_SH; f3_s = 3'd5; f7_s = 7'h20; end
            OP_LB:    begin fmt_s = FMT_I;  opc_s = OPC_LOAD; f3_s = 3'd0; end
            OP_LH:    begin fmt_s = FMT_I;  opc_s = OPC_LOAD; f3_s = 3'd1; end
            OP_LW:    begin fmt_s = FMT_I;  opc_s = OPC_LOAD; f3_s = 3'd2; end
            OP_LBU:   begin fmt_s = FMT_I;  opc_s = OPC_LOAD; f3_s = 3'd4; end
            OP_LHU:   begin fmt_s = FMT_I;  opc_s = OPC_LOAD; f3_s = 3'd5; end
            OP_SB:    begin fmt_s = FMT_S;  opc_s = OPC_STORE; f3_s = 3'd0; end
            OP_SH:    begin fmt_s = FMT_S;  opc_s = OPC_STORE; f3_s = 3'd1; end
            OP_SW:    begin fmt_s = FMT_S;  opc_s = OPC_STORE; f3_s = 3'd2; end
            OP_BEQ:   begin fmt_s = FMT_B;  opc_s = OPC_BRANCH; f3_s = 3'd0; end
            OP_BNE:   begin fmt_s = FMT_B;  opc_s = OPC_BRANCH; f3_s = 3'd1; end
            OP_BLT:   begin fmt_s = FMT_B;  opc_s = OPC_BRANCH; f3_s = 3'd4; end
            OP_BGE:   begin fmt_s = FMT_B;  opc_s = OPC_BRANCH; f3_s = 3'd5; end
            OP_BLTU:  begin fmt_s = FMT_B;  opc_s = OPC_BRANCH; f3_s = 3'd6; end
            OP_BGEU:  begin fmt_s = FMT_B;  opc_s = OPC_BRANCH; f3_s = 3'd7; end
            OP_LUI:   begin fmt_s = FMT_U;  opc_s = OPC_LUI; end
            OP_AUIPC: begin fmt_s = FMT_U;  opc_s = OPC_AUIPC; end
            OP_JAL:   begin fmt_s = FMT_J;  opc_s = OPC_JAL; end
            OP_JALR:  begin fmt_s = FMT_I;  opc_s = OPC_JALR; f3_s = 3'd0; end
            OP_NOP:   begin fmt_s = FMT_NOP; end
            default:  begin illegal = 1'b1; end
        endcase
    end

    // Field packing; B/J drop imm[0] since targets are always even.
    always_comb begin
        raw_s = NOP_INSTR;
        case (fmt_s)
            FMT_R:   raw_s = {f7_s, rs2, rs1, f3_s, rd, opc_s};
            FMT_I:   raw_s = {imm[11:0], rs1, f3_s, rd, opc_s};
            FMT_SH:  raw_s = {f7_s, imm[4:0], rs1, f3_s, rd, opc_s};
            FMT_S:   raw_s = {imm[11:5], rs2, rs1, f3_s, imm[4:0], opc_s};
            FMT_B:   raw_s = {imm[12], imm[10:5], rs2, rs1, f3_s, imm[4:1], imm[11], opc_s};
            FMT_U:   raw_s = {imm[19:0], rd, opc_s};
            FMT_J:   raw_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc_s};
            default: raw_s = NOP_INSTR;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate must be representable in the selected field without loss.
    always_comb begin
        range_fault = 1'b0;
        case (fmt_s)
            FMT_I, FMT_S: range_fault = !fits_signed(imm, 5'd12);
            FMT_SH:       range_fault = (imm[31:5] != 27'd0);
            FMT_B:        range_fault = !fits_signed(imm, 5'd13) || imm[0];
            FMT_J:        range_fault = !fits_signed(imm, 5'd21) || imm[0];
            FMT_U:        range_fault = (imm[31:20] != 12'd0);
            default:      range_fault = 1'b0;
        endcase
    end
`else
    // Upper immediate bits are simply truncated in this build.
    logic unused_imm_s;
    assign unused_imm_s = ^imm[31:21];
    assign range_fault  = 1'b0;
`endif

    assign instr = (illegal || range_fault) ? NOP_INSTR : raw_s;

endmodule

// File: rtl/instr_encoder.sv
// RV32I program streamer: accepts micro-op requests, encodes them and emits
// instruction words with sequential addresses, bounded by a per-run word count.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, cfg_base, cfg_count     run launch (sampled only in IDLE)
//   req_valid/req_ready, req_*     request channel
//   out_valid/out_ready            output channel; out_instr/out_addr held while stalled
//   busy, done, err                status (done is a one-cycle pulse, err is sticky)
// Build option: IMM_RANGE_CHECK_EN (see instr_format_enc).
module instr_encoder
    import enc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    enc_state_e        state_r, state_n;
    logic [CNT_W-1:0]  count_r, accepted_r, emitted_r;
    logic [ADDR_W-1:0] next_addr_r, out_addr_r;
    logic [31:0]       out_instr_r;
    logic              out_valid_r, err_r;

    logic [31:0]       instr_s;
    logic              illegal_s, range_fault_s;
    logic              launch_s, accept_s, out_hs_s, last_word_s;

    instr_format_enc u_fmt (
        .op          (req_op),
        .rd          (req_rd),
        .rs1         (req_rs1),
        .rs2         (req_rs2),
        .imm         (req_imm),
        .instr       (instr_s),
        .illegal     (illegal_s),
        .range_fault (range_fault_s)
    );

    assign launch_s    = (state_r == ST_IDLE) && start;
    assign req_ready   = (state_r == ST_RUN) && (accepted_r < count_r)
                         && (!out_valid_r || out_ready);
    assign accept_s    = req_valid && req_ready;
    assign out_hs_s    = out_valid_r && out_ready;
    assign last_word_s = (emitted_r == count_r - CNT_W'(1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next state; an empty run goes straight to DONE.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n = (cfg_count == CNT_W'(0)) ? ST_DONE : ST_RUN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (out_hs_s && last_word_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Run bookkeeping: word limit, accept/emit counters and next address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= CNT_W'(0);
            accepted_r  <= CNT_W'(0);
            emitted_r   <= CNT_W'(0);
            next_addr_r <= ADDR_W'(0);
        end else if (launch_s) begin
            count_r     <= cfg_count;
            accepted_r  <= CNT_W'(0);
            emitted_r   <= CNT_W'(0);
            next_addr_r <= {cfg_base[ADDR_W-1:2], 2'b00};
        end else begin
            if (accept_s) begin
                accepted_r  <= accepted_r + CNT_W'(1);
                next_addr_r <= next_addr_r + ADDR_W'(4);
            end
            if (out_hs_s) begin
                emitted_r <= emitted_r + CNT_W'(1);
            end
        end
    end

    // Output pipeline register; a same-cycle handshake and accept keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'd0;
            out_addr_r  <= ADDR_W'(0);
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_instr_r <= instr_s;
            out_addr_r  <= next_addr_r;
        end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Sticky error, cleared when a new run is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (launch_s) begin
            err_r <= 1'b0;
        end else if (accept_s && (illegal_s || range_fault_s)) begin
            err_r <= 1'b1;
        end
    end

    assign out_valid = out_valid_r;
    assign out_instr = out_instr_r;
    assign out_addr  = out_addr_r;
    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign err       = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes hand-computed words and
// addresses into a queue, an independent monitor pops and compares on each
// output handshake.
module tb_instr_encoder;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] cfg_base;
    logic [CNT_W-1:0]  cfg_count;
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op;
    logic [4:0]        req_rd, req_rs1, req_rs2;
    logic [31:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              busy, done, err;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_addr;
    int          tests = 0;
    int          fails = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_base  (cfg_base),
        .cfg_count (cfg_count),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: sample between the driving negedge and the next posedge.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got 0x%08h at 0x%08h, none expected", out_instr, out_addr);
            end else begin
                e = sb_q.pop_front();
                check("out_instr", out_instr, e.instr);
                check("out_addr", out_addr, e.addr);
            end
        end
    end

    task automatic start_run(input logic [31:0] base, input logic [15:0] cnt);
        @(negedge clk);
        cfg_base  = base;
        cfg_count = cnt;
        start     = 1'b1;
        exp_addr  = {base[31:2], 2'b00};
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_req(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm,
                             input logic [31:0] exp_instr, input bit push);
        @(negedge clk);
        req_op    = op;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
        req_valid = 1'b1;
        if (push) sb_q.push_back('{exp_instr, exp_addr});
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic wait_accept();
        int n = 0;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
        end
        @(posedge clk);
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input bit push);
        drive_req(op, rd, rs1, rs2, imm, exp_instr, push);
        wait_accept();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        while (!done && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_base  = '0;
        cfg_count = '0;
        req_valid = 1'b0;
        req_op    = '0;
        req_rd    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_imm   = '0;
        out_ready = 1'b1;
        exp_addr  = '0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_flags", {29'd0, busy, done, err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word: ADD x3,x1,x2
        start_run(32'h100, 16'd1);
        check("busy_run", {31'd0, busy}, 32'd1);
        send(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b1);
        wait_done("done_single");

        // Four words back-to-back
        start_run(32'h400, 16'd4);
        send(6'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00093, 1'b1);
        send(6'd26, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b1);
        send(6'd27, 5'd0, 5'd1, 5'd2, 32'd8,         32'h00208463, 1'b1);
        send(6'd33, 5'd5, 5'd0, 5'd0, 32'h12345,     32'h123452B7, 1'b1);
        wait_done("done_four");

        // Output stall: JAL then SRAI with out_ready low for 3 cycles
        start_run(32'h800, 16'd2);
        out_ready = 1'b0;
        send(6'd35, 5'd1, 5'd0, 5'd0, 32'd16, 32'h010000EF, 1'b1);
        drive_req(6'd18, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030D093, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_instr", out_instr, 32'h010000EF);
            check("stall_addr", out_addr, 32'h800);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_accept();
        wait_done("done_stall");

        // Illegal op emits NOP and sets err
        start_run(32'h200, 16'd1);
        send(6'd45, 5'd7, 5'd7, 5'd7, 32'd5, 32'h00000013, 1'b1);
        wait_done("done_illegal");
        check("err_illegal", {31'd0, err}, 32'd1);

        // Next start clears err; ADDI with out-of-range immediate
        start_run(32'h300, 16'd1);
        check("err_cleared", {31'd0, err}, 32'd0);
        send(6'd10, 5'd0, 5'd0, 5'd0, 32'd4096, 32'h00000013, 1'b1);
        wait_done("done_range");
`ifdef IMM_RANGE_CHECK_EN
        check("err_range", {31'd0, err}, 32'd1);
`else
        check("err_range", {31'd0, err}, 32'd0);
`endif

        // Unaligned base near the top of the space: address wraps to 0
        start_run(32'hFFFF_FFFE, 16'd2);
        send(6'd0,  5'd3, 5'd1, 5'd2, 32'd0,         32'h002081B3, 1'b1);
        send(6'd13, 5'd4, 5'd5, 5'd0, 32'hFFFF_F800, 32'h8002C213, 1'b1);
        wait_done("done_wrap");

        // Empty run: DONE the cycle after start, no output
        @(negedge clk);
        cfg_count = 16'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cnt0_done", {30'd0, done, busy}, 32'd3);
        check("cnt0_no_out", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("cnt0_idle", {30'd0, done, busy}, 32'd0);

        // Reset mid-run drops the pending word
        start_run(32'h40, 16'd3);
        out_ready = 1'b0;
        send(6'd35, 5'd1, 5'd0, 5'd0, 32'd16, 32'h010000EF, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_instr", out_instr, 32'd0);
        check("mid_rst_addr", out_addr, 32'd0);
        check("mid_rst_flags", {28'd0, busy, done, err, req_ready}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
